// File: rtl/decoder138_pkg.sv
// Shared definitions for the decoder138 round-robin select sequencer.
// Contents:
//   state_t   - sequencer state encoding (IDLE, GRANT, GAP)
//   NUM_SEL   - number of select lines / requesters
//   IDX_W     - width of a requester index
//   SEL_NONE  - active-low select vector with nothing selected
//   sel_code  - index -> active-low one-hot select (Decoder138 Y encoding)
package decoder138_pkg;

  localparam int NUM_SEL = 8;
  localparam int IDX_W   = 3;
  localparam logic [NUM_SEL-1:0] SEL_NONE = 8'hFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  // Active-low one-hot code for a select index, identical to the 3-to-8 decoder output.
  function automatic logic [NUM_SEL-1:0] sel_code(input logic [IDX_W-1:0] idx);
    logic [NUM_SEL-1:0] one_s;
    one_s = 8'h01;
    return ~(one_s << idx);
  endfunction

endpackage

// File: rtl/rr_pick8.sv
// Combinational round-robin picker for eight requesters.
// Rotates the request vector so that index ptr lands at bit 0, finds the first
// set bit, then adds ptr back to recover the absolute index.
// Ports:
//   req  [7:0] in  - request vector, bit i = requester i
//   ptr  [2:0] in  - highest-priority index
//   pick [2:0] out - winning index (meaningful only when any=1)
//   any        out - at least one request present
module rr_pick8
  import decoder138_pkg::*;
(
  input  logic [NUM_SEL-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   pick,
  output logic               any
);

  logic [NUM_SEL-1:0] rot_s;
  logic [IDX_W-1:0]   off_s;

  // Rotate right by ptr; the 3-bit index sum wraps naturally modulo 8.
  always_comb begin
    rot_s = 8'h00;
    for (int i = 0; i < NUM_SEL; i++) begin
      rot_s[i] = req[IDX_W'(i) + ptr];
    end
  end

  // Find-first-set from bit 0: scanning downward leaves the lowest set bit.
  always_comb begin
    off_s = 3'd0;
    for (int i = NUM_SEL - 1; i >= 0; i--) begin
      if (rot_s[i]) begin
        off_s = IDX_W'(i);
      end else begin
        off_s = off_s;
      end
    end
  end

  assign pick = off_s + ptr;
  assign any  = |req;

endmodule

// File: rtl/decoder138_rr_arbiter.sv
// Round-robin sequencer sharing the eight active-low select lines of a 3-to-8
// decoder among eight requesters. One grant at a time, bounded hold time and a
// turnaround gap with all selects deasserted after every release. Gated by the
// decoder's three-term enable (G1 high, G2An low, G2Bn low).
// Parameters:
//   MAX_HOLD - maximum consecutive GRANT cycles per grant (0 = unlimited)
//   GAP_CYC  - all-deasserted turnaround cycles after each release (0 allowed)
// Ports:
//   clk         in  - system clock, rising edge
//   rst         in  - asynchronous active-high reset
//   G1          in  - enable, active high
//   G2An        in  - enable, active low
//   G2Bn        in  - enable, active low
//   req   [7:0] in  - level-sensitive requests, held until served
//   Y     [7:0] out - registered active-low one-hot select, 8'hFF = none
//   grant_idx   out - registered index of the current/last grant
//   grant_valid out - high while in GRANT
//   timeout     out - one-cycle pulse on a forced (MAX_HOLD) release
module decoder138_rr_arbiter
  import decoder138_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int GAP_CYC  = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               G1,
  input  logic               G2An,
  input  logic               G2Bn,
  input  logic [NUM_SEL-1:0] req,
  output logic [NUM_SEL-1:0] Y,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_valid,
  output logic               timeout
);

  localparam int HOLD_W = $clog2(MAX_HOLD) + 1;
  localparam int GAP_W  = $clog2(GAP_CYC) + 1;
  // Terminal counts; only consulted when the matching parameter is non-zero.
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYC - 1);

  state_t             state_r, state_s;
  logic [IDX_W-1:0]   ptr_r, ptr_s;
  logic [HOLD_W-1:0]  hold_cnt_r, hold_cnt_s;
  logic [GAP_W-1:0]   gap_cnt_r, gap_cnt_s;
  logic [NUM_SEL-1:0] y_r, y_s;
  logic [IDX_W-1:0]   grant_idx_r, grant_idx_s;
  logic               grant_valid_r, grant_valid_s;
  logic               timeout_r, timeout_s;

  logic               en_s;
  logic [IDX_W-1:0]   pick_s;
  logic               any_s;
  logic               rel_req_s;
  logic               rel_hold_s;
  logic               rel_en_s;

  assign en_s = G1 & ~G2An & ~G2Bn;

  rr_pick8 u_pick (
    .req  (req),
    .ptr  (ptr_r),
    .pick (pick_s),
    .any  (any_s)
  );

  // Release conditions evaluated against the current grant.
  assign rel_req_s  = ~req[grant_idx_r];
  assign rel_hold_s = (MAX_HOLD != 0) && (hold_cnt_r == HOLD_LAST);
  assign rel_en_s   = ~en_s;

  // Next-state and next-output logic; outputs are registered from these values.
  always_comb begin
    state_s       = state_r;
    ptr_s         = ptr_r;
    hold_cnt_s    = hold_cnt_r;
    gap_cnt_s     = gap_cnt_r;
    y_s           = y_r;
    grant_idx_s   = grant_idx_r;
    grant_valid_s = grant_valid_r;
    timeout_s     = 1'b0;

    case (state_r)
      IDLE: begin
        if (en_s && any_s) begin
          state_s       = GRANT;
          grant_idx_s   = pick_s;
          y_s           = sel_code(pick_s);
          grant_valid_s = 1'b1;
          hold_cnt_s    = '0;
        end else begin
          y_s           = SEL_NONE;
          grant_valid_s = 1'b0;
        end
      end

      GRANT: begin
        if (rel_req_s || rel_hold_s || rel_en_s) begin
          y_s           = SEL_NONE;
          grant_valid_s = 1'b0;
          ptr_s         = grant_idx_r + 3'd1;
          // Only a pure hold-limit release counts as a timeout.
          timeout_s     = rel_hold_s & ~rel_req_s & ~rel_en_s;
          gap_cnt_s     = '0;
          if (GAP_CYC > 0) begin
            state_s = GAP;
          end else begin
            state_s = IDLE;
          end
        end else begin
          // With unlimited hold the counter is frozen so it can never wrap.
          if (MAX_HOLD != 0) begin
            hold_cnt_s = hold_cnt_r + HOLD_W'(1);
          end else begin
            hold_cnt_s = hold_cnt_r;
          end
        end
      end

      GAP: begin
        y_s           = SEL_NONE;
        grant_valid_s = 1'b0;
        if (gap_cnt_r == GAP_LAST) begin
          state_s = IDLE;
        end else begin
          gap_cnt_s = gap_cnt_r + GAP_W'(1);
        end
      end

      default: begin
        state_s       = IDLE;
        y_s           = SEL_NONE;
        grant_valid_s = 1'b0;
      end
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= IDLE;
      ptr_r         <= 3'd0;
      hold_cnt_r    <= '0;
      gap_cnt_r     <= '0;
      y_r           <= SEL_NONE;
      grant_idx_r   <= 3'd0;
      grant_valid_r <= 1'b0;
      timeout_r     <= 1'b0;
    end else begin
      state_r       <= state_s;
      ptr_r         <= ptr_s;
      hold_cnt_r    <= hold_cnt_s;
      gap_cnt_r     <= gap_cnt_s;
      y_r           <= y_s;
      grant_idx_r   <= grant_idx_s;
      grant_valid_r <= grant_valid_s;
      timeout_r     <= timeout_s;
    end
  end

  assign Y           = y_r;
  assign grant_idx   = grant_idx_r;
  assign grant_valid = grant_valid_r;
  assign timeout     = timeout_r;

endmodule

// File: tb/tb_decoder138_rr_arbiter.sv
// Directed self-checking bench for decoder138_rr_arbiter.
// u_dut uses the default parameters; u_dut_b uses MAX_HOLD=0, GAP_CYC=0.
module tb_decoder138_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       G1, G2An, G2Bn;
  logic [7:0] req, req_b;
  logic [7:0] y, y_b;
  logic [2:0] grant_idx, grant_idx_b;
  logic       grant_valid, grant_valid_b;
  logic       timeout, timeout_b;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  decoder138_rr_arbiter u_dut (
    .clk         (clk),
    .rst         (rst),
    .G1          (G1),
    .G2An        (G2An),
    .G2Bn        (G2Bn),
    .req         (req),
    .Y           (y),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid),
    .timeout     (timeout)
  );

  decoder138_rr_arbiter #(.MAX_HOLD(0), .GAP_CYC(0)) u_dut_b (
    .clk         (clk),
    .rst         (rst),
    .G1          (G1),
    .G2An        (G2An),
    .G2Bn        (G2Bn),
    .req         (req_b),
    .Y           (y_b),
    .grant_idx   (grant_idx_b),
    .grant_valid (grant_valid_b),
    .timeout     (timeout_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] one;
    logic [7:0] exp_y;
    logic [2:0] k;
    int         cnt;

    one   = 8'h01;
    rst   = 1'b1;
    G1    = 1'b1;
    G2An  = 1'b0;
    G2Bn  = 1'b0;
    req   = 8'h00;
    req_b = 8'h00;

    // Reset state
    step();
    step();
    check("rst_y",     32'(y),           32'(8'hFF));
    check("rst_gv",    32'(grant_valid), 32'(1'b0));
    check("rst_idx",   32'(grant_idx),   32'(3'd0));
    check("rst_to",    32'(timeout),     32'(1'b0));
    rst = 1'b0;
    step();

    // Round robin with all requests held: 0..7 then 0 again
    req = 8'hFF;
    step();
    for (int g = 0; g < 9; g++) begin
      k     = 3'(g);
      exp_y = ~(one << k);
      check("rr_y",   32'(y),           32'(exp_y));
      check("rr_idx", 32'(grant_idx),   32'(k));
      check("rr_gv",  32'(grant_valid), 32'(1'b1));
      if (g < 8) begin
        cnt = 0;
        for (int c = 0; c < 15; c++) begin
          step();
          if (y === exp_y && timeout === 1'b0) cnt++;
        end
        check("rr_hold16", 32'(cnt), 32'(15));
        step();
        check("rr_rel_y",  32'(y),           32'(8'hFF));
        check("rr_rel_to", 32'(timeout),     32'(1'b1));
        check("rr_rel_gv", 32'(grant_valid), 32'(1'b0));
        step();
        check("rr_gap2_y",  32'(y),       32'(8'hFF));
        check("rr_gap2_to", 32'(timeout), 32'(1'b0));
        step();
      end
    end
    req = 8'h00;
    step();
    check("rr_end_y",  32'(y),       32'(8'hFF));
    check("rr_end_to", 32'(timeout), 32'(1'b0));
    step();
    step();

    // Early release: three cycles of grant 4, then ptr=5 favours 5 over 0
    req = 8'h10;
    cnt = 0;
    for (int c = 0; c < 3; c++) begin
      step();
      if (y === 8'hEF && timeout === 1'b0) cnt++;
    end
    check("early_3cyc", 32'(cnt), 32'(3));
    req = 8'h00;
    step();
    check("early_rel_y",  32'(y),       32'(8'hFF));
    check("early_rel_to", 32'(timeout), 32'(1'b0));
    req = 8'h21;
    step();
    check("gap_ignore_y", 32'(y), 32'(8'hFF));
    step();
    check("early_next_y",   32'(y),         32'(8'hDF));
    check("early_next_idx", 32'(grant_idx), 32'(3'd5));
    req = 8'h01;
    step();
    step();
    step();
    check("early_then0_y", 32'(y), 32'(8'hFE));
    req = 8'h00;
    step();
    step();

    // Enable gating
    G2An = 1'b1;
    req  = 8'h04;
    step();
    step();
    check("en_off_y", 32'(y), 32'(8'hFF));
    G2An = 1'b0;
    step();
    check("en_on_y", 32'(y), 32'(8'hFB));
    G1 = 1'b0;
    step();
    check("en_drop_y",  32'(y),           32'(8'hFF));
    check("en_drop_to", 32'(timeout),     32'(1'b0));
    check("en_drop_gv", 32'(grant_valid), 32'(1'b0));
    G1 = 1'b1;
    step();
    step();
    check("en_regrant_y", 32'(y), 32'(8'hFB));

    // Asynchronous reset mid-grant, observed before any clock edge
    rst = 1'b1;
    #1;
    check("arst_y",   32'(y),           32'(8'hFF));
    check("arst_gv",  32'(grant_valid), 32'(1'b0));
    check("arst_idx", 32'(grant_idx),   32'(3'd0));
    req = 8'h00;
    step();
    rst = 1'b0;
    step();
    step();
    check("arst_after_y", 32'(y), 32'(8'hFF));

    // Pointer wrap: after index 7, index 0 wins over 7
    req = 8'h80;
    step();
    check("wrap_y7",   32'(y),         32'(8'h7F));
    check("wrap_idx7", 32'(grant_idx), 32'(3'd7));
    req = 8'h00;
    step();
    check("wrap_rel_y", 32'(y), 32'(8'hFF));
    req = 8'h81;
    step();
    step();
    check("wrap_y0",   32'(y),         32'(8'hFE));
    check("wrap_idx0", 32'(grant_idx), 32'(3'd0));
    req = 8'h00;
    step();
    step();
    step();

    // MAX_HOLD=0, GAP_CYC=0 instance: unlimited hold, single idle cycle
    req_b = 8'h02;
    cnt   = 0;
    for (int c = 0; c < 40; c++) begin
      step();
      if (y_b === 8'hFD && timeout_b === 1'b0) cnt++;
    end
    check("b_hold40", 32'(cnt), 32'(40));
    req_b = 8'h00;
    step();
    check("b_rel_y",  32'(y_b),           32'(8'hFF));
    check("b_rel_gv", 32'(grant_valid_b), 32'(1'b0));
    req_b = 8'h02;
    step();
    check("b_regrant_y", 32'(y_b), 32'(8'hFD));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
